// File: rtl/one_bit_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : one_bit_full_adder
// Description : Combinational one-bit full adder with a registered copy of
//               its outputs and an optional bit-serial word mode. In serial
//               mode the carry is kept internally between bits, and the sum
//               bits are assembled LSB-first into sum_word. A one-cycle
//               word_done pulse and a signed overflow flag mark each
//               completed word.
// Ports       :
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   inpa/inpb  in   addend bits
//   cin        in   external carry-in (serial mode: used on the start bit)
//   in_valid   in   qualifies inputs for registered and serial operation
//   serial_en  in   1 = bit-serial word mode, 0 = single-bit mode
//   start      in   first (LSB) bit of a serial word
//   res/cout   out  combinational sum / carry-out
//   res_q/cout_q out registered sum / carry-out
//   out_valid  out  registered valid aligned with res_q/cout_q
//   sum_word   out  assembled serial sum (WIDTH bits)
//   word_done  out  one-cycle pulse when sum_word is complete
//   overflow   out  signed overflow of the completed word
// Revision    : 1.0  initial release
// ============================================================================
module one_bit_full_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inpa,
    input  logic             inpb,
    input  logic             cin,
    output logic             cout,
    output logic             res,
    input  logic             in_valid,
    input  logic             serial_en,
    input  logic             start,
    output logic             res_q,
    output logic             cout_q,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum_word,
    output logic             word_done,
    output logic             overflow
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    logic             r_carry;
    logic [c_CW-1:0]  r_bit_cnt;
    logic             r_res_q;
    logic             r_cout_q;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum_word;
    logic             r_word_done;
    logic             r_overflow;

    logic             w_c_eff;
    logic             w_res;
    logic             w_cout;
    logic [c_CW-1:0]  w_idx;

    // External carry feeds single-bit mode and the first bit of a serial
    // word; every later serial bit chains from the stored carry.
    assign w_c_eff = (!serial_en || start) ? cin : r_carry;
    assign w_res   = inpa ^ inpb ^ w_c_eff;
    assign w_cout  = (inpa & inpb) | (inpa & w_c_eff) | (inpb & w_c_eff);

    // A start bit always lands at position 0, even in the middle of a word.
    assign w_idx   = start ? '0 : r_bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry     <= 1'b0;
            r_bit_cnt   <= '0;
            r_res_q     <= 1'b0;
            r_cout_q    <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum_word  <= '0;
            r_word_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_word_done <= 1'b0;

            if (in_valid) begin
                r_res_q     <= w_res;
                r_cout_q    <= w_cout;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end

            if (serial_en) begin
                if (in_valid) begin
                    r_carry <= w_cout;
                    if (start) begin
                        r_sum_word <= {{(WIDTH-1){1'b0}}, w_res};
                        r_overflow <= 1'b0;
                    end else begin
                        r_sum_word[w_idx] <= w_res;
                    end

                    if (w_idx == c_LAST) begin
                        r_word_done <= 1'b1;
                        // Carry into the MSB is c_eff; differing from the
                        // MSB carry-out means signed overflow.
                        r_overflow  <= w_c_eff ^ w_cout;
                        r_bit_cnt   <= '0;
                    end else begin
                        r_bit_cnt   <= w_idx + c_CW'(1);
                    end
                end
            end else if (r_bit_cnt != '0) begin
                // Leaving serial mode part-way through discards the word.
                r_bit_cnt <= '0;
            end
        end
    end

    assign res       = w_res;
    assign cout      = w_cout;
    assign res_q     = r_res_q;
    assign cout_q    = r_cout_q;
    assign out_valid = r_out_valid;
    assign sum_word  = r_sum_word;
    assign word_done = r_word_done;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_one_bit_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_one_bit_full_adder
// Description : Self-checking bench for one_bit_full_adder (WIDTH=32).
//               Expected values come from whole-word integer arithmetic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_one_bit_full_adder;

    localparam int c_W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           inpa, inpb, cin, in_valid, serial_en, start;
    logic           cout, res, res_q, cout_q, out_valid, word_done, overflow;
    logic [c_W-1:0] sum_word;

    int checks   = 0;
    int failures = 0;

    one_bit_full_adder #(.WIDTH(c_W)) dut (
        .clk(clk), .rst_n(rst_n), .inpa(inpa), .inpb(inpb), .cin(cin),
        .cout(cout), .res(res), .in_valid(in_valid), .serial_en(serial_en),
        .start(start), .res_q(res_q), .cout_q(cout_q), .out_valid(out_valid),
        .sum_word(sum_word), .word_done(word_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Tasks begin and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; serial_en = 1'b0; start = 1'b0;
        inpa = 1'b0; inpb = 1'b0; cin = 1'b0;
        step();
        step();
        checks++;
        if ({res_q, cout_q, out_valid, word_done, overflow} !== 5'b0 || sum_word !== '0) begin
            failures++;
            $display("FAIL reset: flags=%b sum_word=%h required flags=00000 sum_word=0",
                     {res_q, cout_q, out_valid, word_done, overflow}, sum_word);
        end
        #2 rst_n = 1'b1;
        step();
    endtask

    // Single-bit mode: all 8 combinations, then random ones with random in_valid.
    task automatic test_truth_table();
        logic [1:0] exp;
        logic       a, b, c, v;
        serial_en = 1'b0;
        for (int i = 0; i < 28; i++) begin
            if (i < 8) {c, b, a} = 3'(i);
            else       {c, b, a} = 3'($urandom_range(7));
            v = (i < 8) ? 1'b1 : 1'($urandom_range(1));
            inpa = a; inpb = b; cin = c; in_valid = v; start = 1'($urandom_range(1));
            exp = 2'(a) + 2'(b) + 2'(c);
            #1;
            checks++;
            if ({cout, res} !== exp) begin
                failures++;
                $display("FAIL truth_table abc=%b%b%b: {cout,res}=%b required %b", a, b, c, {cout, res}, exp);
            end
            @(posedge clk); #1;
            if (v) begin
                checks++;
                if ({cout_q, res_q, out_valid} !== {exp, 1'b1}) begin
                    failures++;
                    $display("FAIL truth_table_reg abc=%b%b%b: {cout_q,res_q,out_valid}=%b required %b",
                             a, b, c, {cout_q, res_q, out_valid}, {exp, 1'b1});
                end
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_registered();
        serial_en = 1'b0; start = 1'b0;
        inpa = 1'b1; inpb = 1'b1; cin = 1'b1; in_valid = 1'b1;
        step();
        checks++;
        if ({res_q, cout_q, out_valid} !== 3'b111) begin
            failures++;
            $display("FAIL registered_load: {res_q,cout_q,out_valid}=%b required 111", {res_q, cout_q, out_valid});
        end
        inpa = 1'b0; inpb = 1'b0; cin = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if ({res_q, cout_q, out_valid} !== 3'b110) begin
            failures++;
            $display("FAIL registered_hold: {res_q,cout_q,out_valid}=%b required 110", {res_q, cout_q, out_valid});
        end
    endtask

    // Feed nbits of a serial word a+b+c0; stalls inserted when stall is set.
    task automatic do_word(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                           input logic c0, input int nbits, input bit stall,
                           input string name);
        logic [c_W:0] full;
        logic         exp_ovf, exp_c;
        int           ns;
        full    = {1'b0, a} + {1'b0, b} + (c_W+1)'(c0);
        exp_ovf = (a[c_W-1] == b[c_W-1]) && (full[c_W-1] != a[c_W-1]);
        serial_en = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            ns = (stall && $urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
            for (int s = 0; s < ns; s++) begin
                in_valid = 1'b0; start = 1'b0;
                inpa = 1'($urandom_range(1)); inpb = 1'($urandom_range(1)); cin = 1'($urandom_range(1));
                step();
                checks++;
                if (out_valid !== 1'b0 || word_done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s stall bit %0d: out_valid=%b word_done=%b required 0 0", name, i, out_valid, word_done);
                end
            end
            in_valid = 1'b1; start = (i == 0);
            inpa = a[i]; inpb = b[i];
            cin = (i == 0) ? c0 : 1'($urandom_range(1));
            exp_c = (i == c_W-1) ? full[c_W] : (full[i+1] ^ a[i+1] ^ b[i+1]);
            #1;
            checks++;
            if ({cout, res} !== {exp_c, full[i]}) begin
                failures++;
                $display("FAIL %s comb bit %0d: {cout,res}=%b required %b", name, i, {cout, res}, {exp_c, full[i]});
            end
            @(posedge clk); #1;
            checks++;
            if ({cout_q, res_q, out_valid, word_done} !== {exp_c, full[i], 1'b1, 1'(i == c_W-1)}) begin
                failures++;
                $display("FAIL %s reg bit %0d: {cout_q,res_q,out_valid,word_done}=%b required %b", name, i,
                         {cout_q, res_q, out_valid, word_done}, {exp_c, full[i], 1'b1, 1'(i == c_W-1)});
            end
        end
        in_valid = 1'b0; start = 1'b0;
        if (nbits == c_W) begin
            checks++;
            if (sum_word !== full[c_W-1:0] || overflow !== exp_ovf) begin
                failures++;
                $display("FAIL %s word: sum_word=%h overflow=%b required %h %b", name, sum_word, overflow,
                         full[c_W-1:0], exp_ovf);
            end
            step();
            checks++;
            if (word_done !== 1'b0 || sum_word !== full[c_W-1:0] || overflow !== exp_ovf) begin
                failures++;
                $display("FAIL %s hold: word_done=%b sum_word=%h overflow=%b required 0 %h %b", name,
                         word_done, sum_word, overflow, full[c_W-1:0], exp_ovf);
            end
        end
    endtask

    task automatic test_serial_directed();
        do_word(32'h0000FFFF, 32'h00000001, 1'b0, c_W, 1'b0, "add_ffff");
        do_word(32'h7FFFFFFF, 32'h00000001, 1'b0, c_W, 1'b0, "add_7fff");
        do_word(32'hFFFFFFFF, 32'h00000001, 1'b0, c_W, 1'b0, "add_wrap");
        do_word(32'h80000000, 32'h80000000, 1'b1, c_W, 1'b0, "add_negovf");
    endtask

    task automatic test_serial_random();
        for (int k = 0; k < 6; k++)
            do_word($urandom, $urandom, 1'($urandom_range(1)), c_W, 1'b1, "rand_word");
    endtask

    // Restart at bit 10 (start re-asserted), and abandon a word by leaving serial mode.
    task automatic test_abort();
        do_word($urandom, $urandom, 1'b1, 10, 1'b0, "abort_head");
        do_word(32'h12345678, 32'h0FEDCBA9, 1'b0, c_W, 1'b1, "abort_restart");
        do_word($urandom, $urandom, 1'b0, 5, 1'b0, "mode_head");
        serial_en = 1'b0; in_valid = 1'b1;
        step();
        serial_en = 1'b1; start = 1'b0;
        for (int i = 0; i < c_W - 5; i++) begin
            inpa = 1'($urandom_range(1)); inpb = 1'($urandom_range(1));
            step();
            checks++;
            if (word_done !== 1'b0) begin
                failures++;
                $display("FAIL mode_abort bit %0d: word_done=%b required 0", i, word_done);
            end
        end
        in_valid = 1'b0;
        do_word($urandom, $urandom, 1'b1, c_W, 1'b0, "after_mode_abort");
    endtask

    task automatic test_async_reset();
        do_word(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 10, 1'b0, "pre_reset");
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({res_q, cout_q, out_valid, word_done, overflow} !== 5'b0 || sum_word !== '0) begin
            failures++;
            $display("FAIL async_reset: flags=%b sum_word=%h required 00000 0",
                     {res_q, cout_q, out_valid, word_done, overflow}, sum_word);
        end
        serial_en = 1'b1; start = 1'b0; inpa = 1'b1; inpb = 1'b0; cin = 1'b1;
        #1;
        checks++;
        if ({cout, res} !== 2'b01) begin
            failures++;
            $display("FAIL reset_comb: {cout,res}=%b required 01", {cout, res});
        end
        step();
        #3 rst_n = 1'b1;
        step();
        do_word(32'hDEADBEEF, 32'h21524111, 1'b0, c_W, 1'b1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_registered();
        test_serial_directed();
        test_serial_random();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
